// File: rtl/dm9000a_reg_ctrl_if.sv
// Host-side request/response port of the DM9000A register controller.
// The host drives requests as master; the controller answers as slave.
interface dm9000a_reg_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        init_done;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, init_done
    );
endinterface

// File: rtl/dm9000a_reg_ctrl.sv
// DM9000A register access controller: chip reset/power-up, init table, then
// host register reads/writes as index + data bus cycles on the 16-bit bus.
module dm9000a_reg_ctrl #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int GAP_CYC    = 8,
    parameter int RST_CYC    = 1000,
    parameter int PWR_CYC    = 2000
) (
    input  logic               clk100,
    input  logic               rst_n,
    dm9000a_reg_ctrl_if.slave  host,
    inout  wire  [15:0]        ENET_DATA,
    output logic               ENET_CMD,
    output logic               ENET_CS_N,
    output logic               ENET_RD_N,
    output logic               ENET_WR_N,
    output logic               ENET_RST_N
);

    localparam logic [2:0] ST_RST_PULSE = 3'd0;
    localparam logic [2:0] ST_PWR_WAIT  = 3'd1;
    localparam logic [2:0] ST_INIT      = 3'd2;
    localparam logic [2:0] ST_IDLE      = 3'd3;
    localparam logic [2:0] ST_ACCESS    = 3'd4;

    // PH_LOAD is the single cycle after acceptance in which the request is latched.
    localparam logic [2:0] PH_LOAD   = 3'd0;
    localparam logic [2:0] PH_SETUP  = 3'd1;
    localparam logic [2:0] PH_STROBE = 3'd2;
    localparam logic [2:0] PH_HOLD   = 3'd3;
    localparam logic [2:0] PH_GAP    = 3'd4;

    localparam int MAX_A = (RST_CYC > PWR_CYC) ? RST_CYC : PWR_CYC;
    localparam int MAX_B = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_C = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAX_D = (MAX_B > MAX_C) ? MAX_B : MAX_C;
    localparam int MAX_ALL = (MAX_A > MAX_D) ? MAX_A : MAX_D;
    localparam int CNT_W = $clog2(MAX_ALL + 1);

    function automatic logic [CNT_W-1:0] phase_last(input logic [2:0] ph);
        case (ph)
            PH_SETUP:  return CNT_W'(SETUP_CYC - 1);
            PH_STROBE: return CNT_W'(STROBE_CYC - 1);
            PH_HOLD:   return CNT_W'(HOLD_CYC - 1);
            PH_GAP:    return CNT_W'(GAP_CYC - 1);
            default:   return '0;
        endcase
    endfunction

    // Init table entry: {register index, write value}.
    function automatic logic [23:0] init_entry(input logic [1:0] step);
        case (step)
            2'd0:    return {8'h1F, 16'h0000};
            2'd1:    return {8'h00, 16'h0000};
            2'd2:    return {8'hFF, 16'h0080};
            default: return {8'h05, 16'h0031};
        endcase
    endfunction

    logic [2:0]       state_reg, state_next;
    logic [2:0]       phase_reg, phase_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             data_ph_reg, data_ph_next;
    logic [1:0]       step_reg, step_next;
    logic             wr_reg, wr_next;
    logic [7:0]       addr_reg, addr_next;
    logic [15:0]      wdata_reg, wdata_next;
    logic [15:0]      rdata_smp_reg, rdata_smp_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic [15:0]      rsp_rdata_reg, rsp_rdata_next;
    logic             init_done_reg, init_done_next;

    logic             cs_n_reg, cs_n_next;
    logic             rd_n_reg, rd_n_next;
    logic             wr_n_reg, wr_n_next;
    logic             cmd_reg, cmd_next;
    logic             enet_rst_n_reg, enet_rst_n_next;
    logic             doe_reg, doe_next;
    logic [15:0]      dout_reg, dout_next;

    logic             ready;
    logic             bus_active;
    logic             strobe_active;

    assign ready = (state_reg == ST_IDLE) && init_done_reg;

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        cnt_next       = cnt_reg + CNT_W'(1);
        data_ph_next   = data_ph_reg;
        step_next      = step_reg;
        wr_next        = wr_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rdata_smp_next = rdata_smp_reg;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata_reg;
        init_done_next = init_done_reg;

        case (state_reg)
            ST_RST_PULSE: begin
                if (cnt_reg == CNT_W'(RST_CYC - 1)) begin
                    state_next = ST_PWR_WAIT;
                    cnt_next   = '0;
                end
            end
            ST_PWR_WAIT: begin
                if (cnt_reg == CNT_W'(PWR_CYC - 1)) begin
                    state_next   = ST_INIT;
                    phase_next   = PH_SETUP;
                    cnt_next     = '0;
                    data_ph_next = 1'b0;
                    step_next    = 2'd0;
                    wr_next      = 1'b1;
                    {addr_next, wdata_next} = init_entry(2'd0);
                end
            end
            ST_IDLE: begin
                cnt_next = '0;
                if (host.req_valid && ready) begin
                    state_next   = ST_ACCESS;
                    phase_next   = PH_LOAD;
                    data_ph_next = 1'b0;
                    wr_next      = host.req_write;
                    addr_next    = host.req_addr;
                    wdata_next   = host.req_wdata;
                end
            end
            ST_INIT, ST_ACCESS: begin
                if (cnt_reg == phase_last(phase_reg)) begin
                    cnt_next = '0;
                    case (phase_reg)
                        PH_LOAD:   phase_next = PH_SETUP;
                        PH_SETUP:  phase_next = PH_STROBE;
                        PH_STROBE: begin
                            phase_next = PH_HOLD;
                            // Last strobe cycle of a read data cycle: chip data is settled.
                            if (data_ph_reg && !wr_reg)
                                rdata_smp_next = ENET_DATA;
                        end
                        PH_HOLD:   phase_next = PH_GAP;
                        default: begin
                            phase_next = PH_SETUP;
                            if (!data_ph_reg) begin
                                data_ph_next = 1'b1;
                            end else if (state_reg == ST_INIT) begin
                                data_ph_next = 1'b0;
                                if (step_reg == 2'd3) begin
                                    state_next     = ST_IDLE;
                                    init_done_next = 1'b1;
                                end else begin
                                    step_next = step_reg + 2'd1;
                                    {addr_next, wdata_next} = init_entry(step_reg + 2'd1);
                                end
                            end else begin
                                data_ph_next = 1'b0;
                                state_next   = ST_IDLE;
                                if (!wr_reg) begin
                                    rsp_valid_next = 1'b1;
                                    rsp_rdata_next = rdata_smp_reg;
                                end
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_next = ST_RST_PULSE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pins are registered from the next state so they change cleanly on the clock edge.
    always_comb begin
        bus_active    = ((state_next == ST_INIT) || (state_next == ST_ACCESS)) &&
                        ((phase_next == PH_SETUP) || (phase_next == PH_STROBE) ||
                         (phase_next == PH_HOLD));
        strobe_active = bus_active && (phase_next == PH_STROBE);
        cs_n_next       = !bus_active;
        cmd_next        = bus_active && data_ph_next;
        rd_n_next       = !(strobe_active && data_ph_next && !wr_next);
        wr_n_next       = !(strobe_active && (!data_ph_next || wr_next));
        doe_next        = bus_active && (!data_ph_next || wr_next);
        dout_next       = data_ph_next ? wdata_next : {8'h00, addr_next};
        enet_rst_n_next = (state_next != ST_RST_PULSE);
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_RST_PULSE;
            phase_reg      <= PH_LOAD;
            cnt_reg        <= '0;
            data_ph_reg    <= 1'b0;
            step_reg       <= 2'd0;
            wr_reg         <= 1'b0;
            addr_reg       <= 8'h00;
            wdata_reg      <= 16'h0000;
            rdata_smp_reg  <= 16'h0000;
            rsp_valid_reg  <= 1'b0;
            rsp_rdata_reg  <= 16'h0000;
            init_done_reg  <= 1'b0;
            cs_n_reg       <= 1'b1;
            rd_n_reg       <= 1'b1;
            wr_n_reg       <= 1'b1;
            cmd_reg        <= 1'b0;
            enet_rst_n_reg <= 1'b0;
            doe_reg        <= 1'b0;
            dout_reg       <= 16'h0000;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            cnt_reg        <= cnt_next;
            data_ph_reg    <= data_ph_next;
            step_reg       <= step_next;
            wr_reg         <= wr_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_smp_reg  <= rdata_smp_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_rdata_reg  <= rsp_rdata_next;
            init_done_reg  <= init_done_next;
            cs_n_reg       <= cs_n_next;
            rd_n_reg       <= rd_n_next;
            wr_n_reg       <= wr_n_next;
            cmd_reg        <= cmd_next;
            enet_rst_n_reg <= enet_rst_n_next;
            doe_reg        <= doe_next;
            dout_reg       <= dout_next;
        end
    end

    assign ENET_DATA  = doe_reg ? dout_reg : 16'hzzzz;
    assign ENET_CS_N  = cs_n_reg;
    assign ENET_RD_N  = rd_n_reg;
    assign ENET_WR_N  = wr_n_reg;
    assign ENET_CMD   = cmd_reg;
    assign ENET_RST_N = enet_rst_n_reg;

    assign host.req_ready = ready;
    assign host.rsp_valid = rsp_valid_reg;
    assign host.rsp_rdata = rsp_rdata_reg;
    assign host.init_done = init_done_reg;

endmodule

// File: doc/dm9000a_reg_ctrl.md
DM9000A_REG_CTRL -- requirements
Module: dm9000a_reg_ctrl

Interface
REQ-001 SHALL have parameters: SETUP_CYC, default 2, clk100 cycles from CS_N/CMD/data valid to strobe fall.
REQ-002 SHALL have parameter STROBE_CYC, default 2, clk100 cycles RD_N/WR_N held low.
REQ-003 SHALL have parameter HOLD_CYC, default 1, clk100 cycles data/CMD/CS_N held after strobe rise.
REQ-004 SHALL have parameter GAP_CYC, default 8, clk100 cycles CS_N high between bus cycles (2 ENET_CLK periods).
REQ-005 SHALL have parameters RST_CYC, default 1000, chip reset pulse length, and PWR_CYC, default 2000, post-reset wait; all parameters SHALL be >= 1.
REQ-006 SHALL have ports (clock and reset first):
- clk100  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  host access request
- req_ready  out  1  request accepted when req_valid && req_ready at rising clk100
- req_write  in  1  1 = register write, 0 = register read
- req_addr  in  8  DM9000A register index
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse, read data available
- rsp_rdata  out  16  read data, held until next read completes
- init_done  out  1  init table complete, host port open
- ENET_DATA  inout  16  chip data bus
- ENET_CMD, ENET_CS_N, ENET_RD_N, ENET_WR_N, ENET_RST_N  out  1 each  chip control pins
REQ-007 SHALL use one clock, clk100; reset is asynchronous and active-low (rst_n).

Function
REQ-008 SHALL perform each register access as an index cycle (CMD=0, data=req_addr zero-extended, write) followed by a data cycle (CMD=1, write or read).
REQ-009 Each bus cycle SHALL traverse SETUP (SETUP_CYC) -> STROBE (STROBE_CYC) -> HOLD (HOLD_CYC) -> GAP (GAP_CYC); CS_N low in SETUP/STROBE/HOLD, high in GAP; ENET_RD_N or ENET_WR_N low only in STROBE.
REQ-010 ENET_DATA SHALL be driven only in SETUP/STROBE/HOLD of write cycles; high-Z otherwise, including entire read data cycle.
REQ-011 Read data SHALL be sampled from ENET_DATA on the last STROBE cycle of the read data cycle.
REQ-012 Top states SHALL be RST_PULSE, PWR_WAIT, INIT, IDLE, ACCESS; ACCESS and INIT use the REQ-009 phase engine with an index/data flag.
REQ-013 After reset release: RST_PULSE drives ENET_RST_N low RST_CYC cycles, then PWR_WAIT holds ENET_RST_N high PWR_CYC cycles, then INIT.
REQ-014 INIT SHALL issue, in order, writes GPR(0x1F)=0x0000, NCR(0x00)=0x0000, IMR(0xFF)=0x0080, RCR(0x05)=0x0031, then set init_done and enter IDLE.
REQ-015 req_ready SHALL be high only in IDLE with init_done=1; host requests are held off during RST_PULSE/PWR_WAIT/INIT.
REQ-016 Request fields SHALL be registered at acceptance; later changes to req_* SHALL not affect the access in progress.
REQ-017 With defaults, rsp_valid for a read SHALL assert 27 cycles after the accepting edge (2 x 13 bus cycles + 1), in the same cycle req_ready returns high; writes produce no rsp_valid.
REQ-018 Back-to-back requests SHALL be accepted on the cycle req_ready returns; minimum spacing = one full access.
REQ-019 init_done SHALL stay 1 until next reset.

Reset
REQ-020 While rst_n=0 (asynchronously): ENET_CS_N=1, ENET_RD_N=1, ENET_WR_N=1, ENET_CMD=0, ENET_RST_N=0, ENET_DATA high-Z, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, all counters 0.
REQ-021 Reset asserted mid-access SHALL abort it with no rsp_valid; on release the RST_PULSE/PWR_WAIT/INIT sequence restarts in full.

Verification
REQ-022 Release rst_n -> ENET_RST_N low exactly 1000 cycles, high, 2000 cycles later first CS_N fall with CMD=0, data=0x001F.
REQ-023 After init -> exactly 8 bus cycles observed (4 index + 4 data) with values of REQ-014, then init_done=1, req_ready=1.
REQ-024 Host write addr 0x02 data 0x003F -> index cycle 0x0002 CMD=0, data cycle 0x003F CMD=1, WR_N low 2 cycles each, setup 2, hold 1, gap 8; no rsp_valid.
REQ-025 Host read addr 0x28, chip model drives 0x0A46 -> RD_N low 2 cycles, ENET_DATA high-Z, rsp_valid pulse 27 cycles after accept, rsp_rdata=0x0A46.
REQ-026 req_valid held high during INIT -> not accepted until init_done; rst_n pulsed low during read data STROBE -> pins to REQ-020 values immediately, no rsp_valid, init sequence repeats.
